// File: rtl/aes_inv_key_scheduler_pkg.sv
// rtl/aes_inv_key_scheduler_pkg.sv - shared types, constants and GF(2^8) helpers for the key scheduler
package aes_inv_key_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1b;

    function automatic int aes_nk(input int key_size);
        return key_size / 32;
    endfunction

    function automatic int aes_nr(input int key_size);
        return key_size / 32 + 6;
    endfunction

    // Multiply by x in GF(2^8); also advances the round constant.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? RCON_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 for nonzero a, and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_key_word_step.sv
// rtl/aes_key_word_step.sv - one combinational key-expansion step producing w[i] from w[i-1] and w[i-Nk]
module aes_key_word_step #(
    parameter int NK = 4
) (
    input  logic [31:0] i_w_prev,
    input  logic [31:0] i_w_nk,
    input  logic [2:0]  i_i_mod_nk,
    input  logic [7:0]  i_rcon,
    output logic [31:0] o_w_next
);

    logic [31:0] w_rot;
    logic [31:0] w_sub_in;
    logic [31:0] w_sub_out;
    logic [31:0] w_t;

    aes_rot_word u_rot (
        .i_word (i_w_prev),
        .o_word (w_rot)
    );

    // Only one SubWord is ever needed per step, so the rotate is muxed in front of it.
    assign w_sub_in = (i_i_mod_nk == 3'd0) ? w_rot : i_w_prev;

    for (genvar g = 0; g < 4; g++) begin : g_sub
        aes_sub_byte u_sub (
            .i_byte (w_sub_in[8*g +: 8]),
            .o_byte (w_sub_out[8*g +: 8])
        );
    end

    // Select the temp word: rotated+substituted+Rcon, plain substitution (256-bit only), or pass-through.
    always_comb begin
        w_t = i_w_prev;
        if (i_i_mod_nk == 3'd0) begin
            w_t = w_sub_out ^ {i_rcon, 24'h000000};
        end else if (NK > 6 && i_i_mod_nk == 3'd4) begin
            w_t = w_sub_out;
        end
    end

    assign o_w_next = i_w_nk ^ w_t;

endmodule

// File: rtl/aes_rot_word.sv
// rtl/aes_rot_word.sv - AES RotWord: most significant byte moves to the least significant position
module aes_rot_word (
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    assign o_word = {i_word[23:0], i_word[31:24]};

endmodule

// File: rtl/aes_sub_byte.sv
// rtl/aes_sub_byte.sv - AES forward S-box computed as GF(2^8) inverse plus affine map
module aes_sub_byte
    import aes_inv_key_scheduler_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    logic [7:0] w_inv;

    assign w_inv  = gf_inv(i_byte);
    assign o_byte = w_inv
                  ^ {w_inv[6:0], w_inv[7]}
                  ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]}
                  ^ {w_inv[3:0], w_inv[7:4]}
                  ^ 8'h63;

endmodule

// File: rtl/aes_inv_key_scheduler.sv
// rtl/aes_inv_key_scheduler.sv - iterative key expansion with reverse-order round-key streaming
module aes_inv_key_scheduler
    import aes_inv_key_scheduler_pkg::*;
#(
    parameter int KeySize = 128
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_key_valid,
    input  logic [KeySize-1:0] i_key,
    output logic               o_key_ready,
    input  logic               i_replay,
    output logic               o_keys_ok,
    output logic               o_rk_valid,
    input  logic               i_rk_ready,
    output logic [127:0]       o_rk_data,
    output logic [3:0]         o_rk_idx,
    output logic               o_rk_last
);

    localparam int         NK     = aes_nk(KeySize);
    localparam int         NR     = aes_nr(KeySize);
    localparam int         NWORDS = 4 * (NR + 1);
    localparam logic [5:0] NK_W   = 6'(NK);
    localparam logic [5:0] LAST_I = 6'(NWORDS - 1);
    localparam logic [2:0] NK_M1  = 3'(NK - 1);
    localparam logic [3:0] NR_W   = 4'(NR);

    state_t        r_state;
    state_t        w_state_next;
    logic [5:0]    r_i;
    logic [2:0]    r_mod;
    logic [7:0]    r_rcon;
    logic          r_keys_ok;
    logic [3:0]    r_ptr;
    logic          r_rk_valid;
    logic [127:0]  r_rk_data;
    logic [3:0]    r_rk_idx;
    logic          r_rk_last;
    logic [31:0]   r_w [NWORDS];

    logic          w_key_fire;
    logic          w_replay_fire;
    logic          w_rk_fire;
    logic          w_expand_done;
    logic          w_load;
    logic [5:0]    w_base;
    logic [127:0]  w_rd_data;
    logic [31:0]   w_w_prev;
    logic [31:0]   w_w_nk;
    logic [31:0]   w_w_next;

    assign w_key_fire    = (r_state == ST_IDLE) && i_key_valid;
    assign w_replay_fire = (r_state == ST_IDLE) && i_replay && r_keys_ok && !i_key_valid;
    assign w_rk_fire     = r_rk_valid && i_rk_ready;
    assign w_expand_done = (r_state == ST_EXPAND) && (r_i == LAST_I);
    // The output register refills when empty or when a non-final beat is consumed.
    assign w_load        = (r_state == ST_STREAM) && (!r_rk_valid || (w_rk_fire && !r_rk_last));

    assign w_w_prev = r_w[r_i - 6'd1];
    assign w_w_nk   = r_w[r_i - NK_W];

    assign w_base    = {r_ptr, 2'b00};
    assign w_rd_data = {r_w[w_base + 6'd3], r_w[w_base + 6'd2], r_w[w_base + 6'd1], r_w[w_base]};

    aes_key_word_step #(
        .NK (NK)
    ) u_step (
        .i_w_prev   (w_w_prev),
        .i_w_nk     (w_w_nk),
        .i_i_mod_nk (r_mod),
        .i_rcon     (r_rcon),
        .o_w_next   (w_w_next)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state decode: a new key takes priority over a replay request.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_key_fire)         w_state_next = ST_EXPAND;
                else if (w_replay_fire) w_state_next = ST_STREAM;
            end
            ST_EXPAND: begin
                if (w_expand_done) w_state_next = ST_STREAM;
            end
            ST_STREAM: begin
                if (w_rk_fire && r_rk_last) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Expansion counters: word index, index modulo Nk, and the running round constant.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_i       <= 6'd0;
            r_mod     <= 3'd0;
            r_rcon    <= RCON_INIT;
            r_keys_ok <= 1'b0;
        end else if (w_key_fire) begin
            r_i       <= NK_W;
            r_mod     <= 3'd0;
            r_rcon    <= RCON_INIT;
            r_keys_ok <= 1'b0;
        end else if (r_state == ST_EXPAND) begin
            r_i   <= r_i + 6'd1;
            r_mod <= (r_mod == NK_M1) ? 3'd0 : r_mod + 3'd1;
            if (r_mod == 3'd0) r_rcon <= xtime(r_rcon);
            if (w_expand_done) r_keys_ok <= 1'b1;
        end
    end

    // Round-key store: key words on acceptance, one expanded word per EXPAND cycle.
    always_ff @(posedge i_clk) begin
        if (w_key_fire) begin
            for (int k = 0; k < NK; k++) r_w[k] <= i_key[KeySize-1-32*k -: 32];
        end else if (r_state == ST_EXPAND) begin
            r_w[r_i] <= w_w_next;
        end
    end

    // Output beat register and round pointer; beats hold while the consumer stalls.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr      <= 4'd0;
            r_rk_valid <= 1'b0;
            r_rk_data  <= 128'd0;
            r_rk_idx   <= 4'd0;
            r_rk_last  <= 1'b0;
        end else if (w_expand_done || w_replay_fire) begin
            r_ptr <= NR_W;
        end else if (w_load) begin
            r_rk_valid <= 1'b1;
            r_rk_data  <= w_rd_data;
            r_rk_idx   <= r_ptr;
            r_rk_last  <= (r_ptr == 4'd0);
            r_ptr      <= r_ptr - 4'd1;
        end else if (w_rk_fire && r_rk_last) begin
            r_rk_valid <= 1'b0;
            r_rk_last  <= 1'b0;
        end
    end

    assign o_key_ready = (r_state == ST_IDLE);
    assign o_keys_ok   = r_keys_ok;
    assign o_rk_valid  = r_rk_valid;
    assign o_rk_data   = r_rk_data;
    assign o_rk_idx    = r_rk_idx;
    assign o_rk_last   = r_rk_last;

endmodule
